// File: rtl/row_col_dec_pkg.sv
// Shared definitions for the capacitor-bank row/column decoder.
//   DEF_ROW_W   default log2 of rows (= log2 of cols)
//   DEF_CNT_W   default width of the saturating error counter
//   reset_word  tuning word matching the bank's half-on reset state
//   popcount    number of set bits in a vector (up to 64 bits)
//   onehot_index  index of the lowest set bit (0 when none set)
package row_col_dec_pkg;

    localparam int unsigned DEF_ROW_W = 4;
    localparam int unsigned DEF_CNT_W = 8;

    function automatic int unsigned reset_word(input int unsigned size);
        return size * size / 2;
    endfunction

    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < 64; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

    // Only meaningful for one-hot inputs; callers must check popcount separately.
    function automatic int unsigned onehot_index(input logic [63:0] v);
        int unsigned idx;
        idx = 0;
        for (int i = 63; i >= 0; i--) begin
            if (v[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/row_col_dec_sel_pattern_chk.sv
// Combinational checker for one sampled selector pattern.
// Inputs:
//   r_all    zero-active full-row enables
//   row      one-hot partially-filled row select
//   col      thermometer column enables of the partial row
// Outputs:
//   r        index of the selected row (valid only when !err_row)
//   c        number of enabled columns, low ROW_W bits
//   err_row  row is not one-hot
//   err_rall r_all does not mark exactly the rows at and above r
//   err_col  col is not a legal thermometer for row r (or is completely full)
module row_col_dec_sel_pattern_chk
    import row_col_dec_pkg::*;
#(
    parameter int unsigned ROW_W = DEF_ROW_W,
    parameter int unsigned SIZE  = 1 << ROW_W
) (
    input  logic [SIZE-1:0]  r_all,
    input  logic [SIZE-1:0]  row,
    input  logic [SIZE-1:0]  col,
    output logic [ROW_W-1:0] r,
    output logic [ROW_W-1:0] c,
    output logic             err_row,
    output logic             err_rall,
    output logic             err_col
);

    int unsigned     row_ones;
    int unsigned     col_ones;
    logic [SIZE-1:0] exp_rall;
    logic [SIZE-1:0] exp_col;

    always_comb begin
        row_ones = popcount(64'(row));
        col_ones = popcount(64'(col));
        r        = ROW_W'(onehot_index(64'(row)));
        c        = ROW_W'(col_ones);

        // Expected buses rebuilt from (r, c): rows r and above are "not full"
        // (zero-active), and the partial row fills from LSB on even rows,
        // from MSB on odd rows (serpentine ordering).
        exp_rall = '0;
        exp_col  = '0;
        for (int unsigned i = 0; i < SIZE; i++) begin
            exp_rall[i] = (i >= 32'(r));
            exp_col[i]  = r[0] ? (i >= SIZE - col_ones) : (i < col_ones);
        end

        err_row  = (row_ones != 1);
        // Without a unique row index the other checks have no reference.
        err_rall = !err_row && (r_all != exp_rall);
        // A full row is never left as the partial row by the encoder.
        err_col  = !err_row && ((col_ones == SIZE) || (col != exp_col));
    end

endmodule

// File: rtl/row_col_dec.sv
// Read-back decoder for the DCO capacitor-bank row/column selector buses.
// Reconstructs the binary tuning word and flags patterns the encoder never makes.
// Two-stage pipeline: S1 captures the buses, S2 decodes and registers outputs.
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   en        sample enable
//   clr       synchronous clear of err_cnt (wins over increment)
//   r_all     zero-active full-row enables
//   row       one-hot partial row select
//   col       thermometer column enables for the partial row
//   word      reconstructed tuning word (holds last good value on errors)
//   valid     one-cycle strobe per decoded sample
//   err_row   row not one-hot
//   err_rall  r_all inconsistent with row index
//   err_col   col illegal for row index
//   err_cnt   saturating count of erroneous samples
module row_col_dec
    import row_col_dec_pkg::*;
#(
    parameter int unsigned ROW_W  = DEF_ROW_W,
    parameter int unsigned WORD_W = 2 * ROW_W,
    parameter int unsigned SIZE   = 1 << ROW_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [SIZE-1:0]   r_all,
    input  logic [SIZE-1:0]   row,
    input  logic [SIZE-1:0]   col,
    output logic [WORD_W-1:0] word,
    output logic              valid,
    output logic              err_row,
    output logic              err_rall,
    output logic              err_col,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam logic [WORD_W-1:0] RST_WORD = WORD_W'(reset_word(SIZE));
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [SIZE-1:0]  s1_r_all;
    logic [SIZE-1:0]  s1_row;
    logic [SIZE-1:0]  s1_col;
    logic             s1_vld;

    logic [ROW_W-1:0] chk_r;
    logic [ROW_W-1:0] chk_c;
    logic             chk_err_row;
    logic             chk_err_rall;
    logic             chk_err_col;
    logic             chk_any;

    // Stage 1: capture; contents hold while en is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_r_all <= '0;
            s1_row   <= '0;
            s1_col   <= '0;
            s1_vld   <= 1'b0;
        end else begin
            s1_vld <= en;
            if (en) begin
                s1_r_all <= r_all;
                s1_row   <= row;
                s1_col   <= col;
            end
        end
    end

    row_col_dec_sel_pattern_chk #(
        .ROW_W (ROW_W),
        .SIZE  (SIZE)
    ) u_sel_pattern_chk (
        .r_all    (s1_r_all),
        .row      (s1_row),
        .col      (s1_col),
        .r        (chk_r),
        .c        (chk_c),
        .err_row  (chk_err_row),
        .err_rall (chk_err_rall),
        .err_col  (chk_err_col)
    );

    assign chk_any = chk_err_row | chk_err_rall | chk_err_col;

    // Stage 2: registered outputs; flags are qualified by valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word     <= RST_WORD;
            valid    <= 1'b0;
            err_row  <= 1'b0;
            err_rall <= 1'b0;
            err_col  <= 1'b0;
        end else begin
            valid <= s1_vld;
            if (s1_vld) begin
                err_row  <= chk_err_row;
                err_rall <= chk_err_rall;
                err_col  <= chk_err_col;
                if (!chk_any) begin
                    word <= {chk_r, chk_c};
                end
            end else begin
                err_row  <= 1'b0;
                err_rall <= 1'b0;
                err_col  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt <= '0;
        end else if (clr) begin
            err_cnt <= '0;
        end else if (s1_vld && chk_any && (err_cnt != CNT_MAX)) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_row_col_dec.sv
// Randomised scoreboard bench for row_col_dec (default 16x16 bank).
module tb_row_col_dec;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        clr;
    logic [15:0] r_all;
    logic [15:0] row;
    logic [15:0] col;
    logic [7:0]  word;
    logic        valid;
    logic        err_row;
    logic        err_rall;
    logic        err_col;
    logic [7:0]  err_cnt;

    row_col_dec dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr      (clr),
        .r_all    (r_all),
        .row      (row),
        .col      (col),
        .word     (word),
        .valid    (valid),
        .err_row  (err_row),
        .err_rall (err_rall),
        .err_col  (err_col),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] word;
        logic       er;
        logic       ea;
        logic       ec;
    } exp_t;

    exp_t q[$];
    int   total     = 0;
    int   bad       = 0;
    int   last_good = 128;
    int   cnt_model = 0;
    int   nvalid    = 0;
    int   nsent     = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what the encoder would have driven for (r, c), compared as whole words.
    function automatic exp_t model(input logic [15:0] ra, input logic [15:0] rw,
                                   input logic [15:0] cl);
        exp_t e;
        int   r;
        int   c;
        int   want_rall;
        int   want_col;
        e = '0;
        if ($countones(rw) != 1) begin
            e.er   = 1'b1;
            e.word = 8'(last_good);
            return e;
        end
        r         = $clog2(rw);
        c         = $countones(cl);
        want_rall = (32'hFFFF << r) & 32'hFFFF;
        if (r % 2 == 0) want_col = (1 << c) - 1;
        else            want_col = (32'hFFFF << (16 - c)) & 32'hFFFF;
        e.ea = ({16'h0, ra} != want_rall);
        e.ec = (c == 16) || ({16'h0, cl} != want_col);
        if (!e.ea && !e.ec) last_good = r * 16 + c;
        e.word = 8'(last_good);
        return e;
    endfunction

    task automatic encode(input int w, output logic [15:0] ra, output logic [15:0] rw,
                          output logic [15:0] cl);
        int r;
        int c;
        r  = w / 16;
        c  = w % 16;
        rw = 16'(1 << r);
        ra = 16'(32'hFFFF << r);
        cl = (r % 2 == 0) ? 16'((1 << c) - 1) : 16'(32'hFFFF << (16 - c));
    endtask

    task automatic send(input logic [15:0] ra, input logic [15:0] rw, input logic [15:0] cl,
                        input logic e, input logic cr);
        @(negedge clk);
        r_all = ra;
        row   = rw;
        col   = cl;
        en    = e;
        clr   = cr;
        if (e) begin
            q.push_back(model(ra, rw, cl));
            nsent++;
        end
    endtask

    task automatic drain();
        repeat (4) send(16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("drain_queue", q.size(), 0);
    endtask

    // Monitor: pops an expectation on every valid and tracks the error counter.
    initial begin : monitor
        exp_t e;
        logic clr_s;
        logic any;
        forever begin
            @(posedge clk);
            clr_s = clr;
            #1;
            if (rst) begin
                any = 1'b0;
                if (valid) begin
                    nvalid++;
                    if (q.size() == 0) begin
                        chk("unexpected_valid", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("word", word, e.word);
                        chk("err_flags", {err_row, err_rall, err_col}, {e.er, e.ea, e.ec});
                        any = e.er | e.ea | e.ec;
                    end
                end else begin
                    chk("idle_flags", {err_row, err_rall, err_col}, 0);
                end
                if (clr_s) cnt_model = 0;
                else if (any && cnt_model < 255) cnt_model++;
                chk("err_cnt", err_cnt, cnt_model);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : main
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c2;
        int          k;
        bit          sent;

        rst = 1'b1; en = 1'b0; clr = 1'b0;
        r_all = '0; row = '0; col = '0;
        #1 rst = 1'b0;
        #2;
        chk("reset_word", word, 8'h80);
        chk("reset_valid", valid, 0);
        chk("reset_flags", {err_row, err_rall, err_col}, 0);
        chk("reset_err_cnt", err_cnt, 0);
        @(negedge clk);
        rst = 1'b1;

        // Directed legal and illegal patterns, back to back.
        send(16'hFF00, 16'h0100, 16'h0000, 1'b1, 1'b0);
        send(16'hFFFC, 16'h0004, 16'h0007, 1'b1, 1'b0);
        send(16'hFFF8, 16'h0008, 16'hF800, 1'b1, 1'b0);
        send(16'hFFF8, 16'h0012, 16'h0000, 1'b1, 1'b0);
        send(16'hFFF8, 16'h0008, 16'h001F, 1'b1, 1'b0);
        send(16'hFFF0, 16'h0008, 16'hF800, 1'b1, 1'b0);
        send(16'hFFFC, 16'h0004, 16'hFFFF, 1'b1, 1'b0);
        drain();
        chk("word_hold", word, 8'h35);
        chk("err_cnt_directed", err_cnt, 4);
        chk("directed_valid_count", nvalid, nsent);

        // Saturation, then clear coinciding with an erroneous output.
        repeat (300) send(16'hFFFF, 16'h0012, 16'h0000, 1'b1, 1'b0);
        drain();
        chk("err_cnt_sat", err_cnt, 255);
        send(16'hFFFF, 16'h0012, 16'h0000, 1'b1, 1'b0);
        send(16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1);
        drain();
        chk("err_cnt_clr", err_cnt, 0);

        // Every encoder-legal word with en toggling randomly.
        nvalid = 0;
        nsent  = 0;
        for (int w = 0; w < 256; w++) begin
            sent = 1'b0;
            while (!sent) begin
                if ($urandom_range(0, 2) != 0) begin
                    encode(w, a, b, c2);
                    send(a, b, c2, 1'b1, 1'b0);
                    sent = 1'b1;
                end else begin
                    send(16'($urandom), 16'($urandom), 16'($urandom), 1'b0, 1'b0);
                end
            end
        end
        drain();
        chk("exhaustive_valid_count", nvalid, nsent);
        chk("exhaustive_err_cnt", err_cnt, 0);

        // Random mix of legal, corrupted and arbitrary patterns.
        repeat (1500) begin
            encode($urandom_range(0, 255), a, b, c2);
            case ($urandom_range(0, 4))
                2: begin
                    k = $urandom_range(0, 15);
                    case ($urandom_range(0, 2))
                        0:       a[k]  = ~a[k];
                        1:       b[k]  = ~b[k];
                        default: c2[k] = ~c2[k];
                    endcase
                end
                3: begin
                    a  = 16'($urandom);
                    b  = 16'($urandom);
                    c2 = 16'($urandom);
                end
                4:       c2 = 16'hFFFF;
                default: ;
            endcase
            send(a, b, c2, $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
        end
        drain();

        // Reset mid-stream: an in-flight legal sample must vanish.
        send(16'hFFFF, 16'h0012, 16'h0000, 1'b1, 1'b0);
        send(16'hFFFC, 16'h0004, 16'h0007, 1'b1, 1'b0);
        @(negedge clk);
        en = 1'b0;
        #2 rst = 1'b0;
        q.delete();
        last_good = 128;
        cnt_model = 0;
        #1;
        chk("midreset_word", word, 8'h80);
        chk("midreset_valid", valid, 0);
        chk("midreset_flags", {err_row, err_rall, err_col}, 0);
        chk("midreset_err_cnt", err_cnt, 0);
        @(negedge clk);
        rst = 1'b1;

        // Latency: valid only after the second rising edge.
        send(16'hFFFC, 16'h0004, 16'h0007, 1'b1, 1'b0);
        @(posedge clk);
        #2 chk("latency_edge1", valid, 0);
        send(16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        @(posedge clk);
        #2 chk("latency_edge2", valid, 1);
        drain();
        chk("final_word", word, 8'h23);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
